// File: rtl/dmem_axi_lite_slave.sv
// AXI4-Lite slave in front of a byte-strobed synchronous data RAM, with independent read/write FSMs.
// Optional build macro DMEM_RANGE_CHECK_EN: out-of-range accesses get SLVERR instead of wrapping.
module dmem_axi_lite_slave #(
  parameter int                    MEM_BYTES  = 532480,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   i_axi_awaddr,
  input  logic                    i_axi_awvalid,
  output logic                    o_axi_awready,
  input  logic [DATA_WIDTH-1:0]   i_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_axi_wstrb,
  input  logic                    i_axi_wvalid,
  output logic                    o_axi_wready,
  output logic [1:0]              o_axi_bresp,
  output logic                    o_axi_bvalid,
  input  logic                    i_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   i_axi_araddr,
  input  logic                    i_axi_arvalid,
  output logic                    o_axi_arready,
  output logic [DATA_WIDTH-1:0]   o_axi_rdata,
  output logic [1:0]              o_axi_rresp,
  output logic                    o_axi_rvalid,
  input  logic                    i_axi_rready
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int DEPTH = MEM_BYTES / NB;
  localparam int IDXW  = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_MEM = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_MEM = 2'd1, R_DATA = 2'd2} rstate_t;

  // Word index relative to BASE_ADDR; wraps modulo DEPTH when range checking is off.
  function automatic logic [IDXW-1:0] f_idx(input logic [ADDR_WIDTH-1:0] addr);
    f_idx = IDXW'(((addr - BASE_ADDR) >> LSB) % ADDR_WIDTH'(DEPTH));
  endfunction

`ifdef DMEM_RANGE_CHECK_EN
  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
    f_in_range = (addr >= BASE_ADDR) &&
                 ({1'b0, (addr - BASE_ADDR)} < (ADDR_WIDTH+1)'(MEM_BYTES));
  endfunction
`endif

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  wstate_t               r_wstate;
  rstate_t               r_rstate;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_wstrb;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_aw_have;
  logic            w_w_have;
  logic            w_ar_hs;
  logic [IDXW-1:0] w_wr_idx;
  logic [IDXW-1:0] w_rd_idx;
  logic            w_wr_ok;
  logic            w_rd_ok;
  logic [1:0]      w_wr_resp;
  logic [1:0]      w_rd_resp;

  assign w_aw_hs   = i_axi_awvalid & r_awready;
  assign w_w_hs    = i_axi_wvalid & r_wready;
  assign w_aw_have = r_aw_done | w_aw_hs;
  assign w_w_have  = r_w_done | w_w_hs;
  assign w_ar_hs   = i_axi_arvalid & r_arready;
  assign w_wr_idx  = f_idx(r_awaddr);
  assign w_rd_idx  = f_idx(r_araddr);

`ifdef DMEM_RANGE_CHECK_EN
  assign w_wr_ok   = f_in_range(r_awaddr);
  assign w_rd_ok   = f_in_range(r_araddr);
  assign w_wr_resp = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
  assign w_rd_resp = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
`else
  assign w_wr_ok   = 1'b1;
  assign w_rd_ok   = 1'b1;
  assign w_wr_resp = RESP_OKAY;
  assign w_rd_resp = RESP_OKAY;
`endif

  // Write FSM: AW and W are captured independently; each ready drops once its channel is held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr  <= i_axi_awaddr;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wdata  <= i_axi_wdata;
            r_wstrb  <= i_axi_wstrb;
            r_w_done <= 1'b1;
          end
          if (w_aw_have && w_w_have) begin
            r_wstate  <= W_MEM;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
          end else begin
            r_awready <= ~w_aw_have;
            r_wready  <= ~w_w_have;
          end
        end
        W_MEM: begin
          r_bvalid <= 1'b1;
          r_bresp  <= w_wr_resp;
          r_wstate <= W_RESP;
        end
        W_RESP: begin
          if (i_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          r_wstate  <= W_IDLE;
          r_bvalid  <= 1'b0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane commit; the array has no reset so its contents survive resetn.
  always_ff @(posedge clk) begin
    if ((r_wstate == W_MEM) && w_wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (r_wstrb[b]) begin
          r_mem[w_wr_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read FSM: reading in R_MEM on the same edge as a W_MEM commit returns the old word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate  <= R_IDLE;
      r_araddr  <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_araddr  <= i_axi_araddr;
            r_arready <= 1'b0;
            r_rstate  <= R_MEM;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_MEM: begin
          r_rdata  <= w_rd_ok ? r_mem[w_rd_idx] : '0;
          r_rresp  <= w_rd_resp;
          r_rvalid <= 1'b1;
          r_rstate <= R_DATA;
        end
        R_DATA: begin
          if (i_axi_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: begin
          r_rstate <= R_IDLE;
          r_rvalid <= 1'b0;
        end
      endcase
    end
  end

  assign o_axi_awready = r_awready;
  assign o_axi_wready  = r_wready;
  assign o_axi_bresp   = r_bresp;
  assign o_axi_bvalid  = r_bvalid;
  assign o_axi_arready = r_arready;
  assign o_axi_rdata   = r_rdata;
  assign o_axi_rresp   = r_rresp;
  assign o_axi_rvalid  = r_rvalid;

endmodule
